// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Each frame is start(0), DATA_BITS payload bits LSB first, an optional
// parity bit, then STOP_BITS stop bits. Every bit lasts baud_div+1 clocks.
// Consecutive frames run back to back when tx_valid is held.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   baud_div   clocks per bit minus 1, captured when a word is accepted
//   tx_data    word to send, captured when a word is accepted
//   tx_valid   tx_data is valid
//   tx_ready   word accepted on an edge where tx_valid && tx_ready
//   uart_tx    serial line, idles high
//   tx_done    one-cycle pulse after the last stop bit
//   uart_state high while a frame is on the line
//
// state | meaning
// IDLE  | line high, ready for a word
// START | start bit (0)
// DATA  | payload bits, LSB first
// PAR   | parity bit (only when parity is enabled)
// STOP  | stop bit(s)
module uart_tx_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_tx,
  output logic                 tx_done,
  output logic                 uart_state
);

  // Unknown parity codes fall back to no parity.
  localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);
  localparam bit ODD_PAR = (PARITY == 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_nxt;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     cnt, cnt_nxt;
  logic [3:0]           idx, idx_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic                 par_q, par_nxt;
  logic                 wrap;
  logic                 done_nxt;
  logic                 line_nxt;

  assign wrap = (cnt == div_q);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift_q;
    par_nxt   = par_q;
    done_nxt  = 1'b0;
    line_nxt  = 1'b1;

    if (state != IDLE)
      cnt_nxt = wrap ? '0 : cnt + 1'b1;

    case (state)
      IDLE: begin
        if (tx_valid) begin
          state_nxt = START;
          shift_nxt = tx_data;
          par_nxt   = (^tx_data) ^ ODD_PAR;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (wrap) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        if (wrap) begin
          if (idx == LAST_DATA) begin
            state_nxt = HAS_PAR ? PAR : STOP;
            idx_nxt   = '0;
          end else begin
            idx_nxt   = idx + 1'b1;
            shift_nxt = shift_q >> 1;
          end
        end
      end
      PAR: begin
        if (wrap) begin
          state_nxt = STOP;
          idx_nxt   = '0;
        end
      end
      STOP: begin
        if (wrap) begin
          if (idx == LAST_STOP) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line value is decoded from the next state so uart_tx can be a flop.
    case (state_nxt)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = shift_nxt[0];
      PAR:     line_nxt = par_nxt;
      default: line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      uart_tx    <= 1'b1;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      shift_q    <= shift_nxt;
      par_q      <= par_nxt;
      if (state == IDLE && tx_valid)
        div_q <= baud_div;
      uart_tx    <= line_nxt;
      tx_ready   <= (state_nxt == IDLE);
      tx_done    <= done_nxt;
      uart_state <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
`timescale 1ns/1ps
module tb_uart_tx_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic [7:0]  tx_data;
  logic        valid [4];
  logic        ready [4];
  logic        line  [4];
  logic        done  [4];
  logic        busy  [4];

  always #5 clk = ~clk;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
  uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .baud_div(baud_div), .tx_data(tx_data),
    .tx_valid(valid[0]), .tx_ready(ready[0]), .uart_tx(line[0]),
    .tx_done(done[0]), .uart_state(busy[0]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .baud_div(baud_div), .tx_data(tx_data),
    .tx_valid(valid[1]), .tx_ready(ready[1]), .uart_tx(line[1]),
    .tx_done(done[1]), .uart_state(busy[1]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DIV_W(16)) u_dut2 (
    .clk(clk), .reset(reset), .baud_div(baud_div), .tx_data(tx_data),
    .tx_valid(valid[2]), .tx_ready(ready[2]), .uart_tx(line[2]),
    .tx_done(done[2]), .uart_state(busy[2]));
  uart_tx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .DIV_W(16)) u_dut3 (
    .clk(clk), .reset(reset), .baud_div(baud_div), .tx_data(tx_data[6:0]),
    .tx_valid(valid[3]), .tx_ready(ready[3]), .uart_tx(line[3]),
    .tx_done(done[3]), .uart_state(busy[3]));

  typedef struct packed {
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [15:0] div;
  } item_t;

  item_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  bit    mon_busy = 1'b0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int n_data(input int sel);
    return (sel == 3) ? 7 : 8;
  endfunction
  function automatic int par_mode(input int sel);
    return (sel == 1) ? 2 : (sel == 2) ? 1 : 0;
  endfunction
  function automatic int n_stop(input int sel);
    return (sel == 3) ? 2 : 1;
  endfunction
  function automatic int frame_len(input int sel);
    return 1 + n_data(sel) + ((par_mode(sel) != 0) ? 1 : 0) + n_stop(sel);
  endfunction

  // Expected line value for frame bit b (0 = start bit).
  function automatic int exp_bit(input int sel, input logic [7:0] d, input int b);
    int nd = n_data(sel);
    int x  = 0;
    if (b == 0) return 0;
    if (b <= nd) return int'(d[b-1]);
    if (par_mode(sel) != 0 && b == nd + 1) begin
      for (int i = 0; i < nd; i++) x = x ^ int'(d[i]);
      return (par_mode(sel) == 2) ? x : 1 - x;
    end
    return 1;
  endfunction

  // Called on the first negedge after the transfer edge; walks every cycle
  // of the frame, then checks the end-of-frame cycle.
  task automatic check_frame(input item_t it);
    int s   = int'(it.sel);
    int n   = frame_len(s);
    int div = int'(it.div);
    int bad_busy = 0, bad_rdy = 0, bad_done = 0;
    for (int b = 0; b < n; b++) begin
      int v = 0;
      for (int c = 0; c <= div; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (c == 0) v = line[s] ? 1 : 0;
        else if ((line[s] ? 1 : 0) != v) v = 2;
        if (busy[s] !== 1'b1) bad_busy++;
        if (ready[s] !== 1'b0) bad_rdy++;
        if (done[s] !== 1'b0) bad_done++;
      end
      check_eq($sformatf("dut%0d data%02h bit%0d", s, it.data, b), v, exp_bit(s, it.data, b));
    end
    check_eq($sformatf("dut%0d busy-low cycles in frame", s), bad_busy, 0);
    check_eq($sformatf("dut%0d ready-high cycles in frame", s), bad_rdy, 0);
    check_eq($sformatf("dut%0d early tx_done cycles", s), bad_done, 0);
    @(negedge clk);
    check_eq($sformatf("dut%0d tx_done at end", s), int'(done[s]), 1);
    check_eq($sformatf("dut%0d uart_state at end", s), int'(busy[s]), 0);
    check_eq($sformatf("dut%0d tx_ready at end", s), int'(ready[s]), 1);
    check_eq($sformatf("dut%0d line at end", s), int'(line[s]), 1);
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        mon_busy = 1'b1;
        check_frame(it);
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send(input int sel, input logic [7:0] d, input int div,
                      input bit hold, input bit push);
    int    t = 0;
    logic  r;
    item_t it;
    @(negedge clk);
    tx_data    = d;
    baud_div   = 16'(div);
    valid[sel] = 1'b1;
    r = ready[sel];
    while (r !== 1'b1 && t < 2000) begin
      @(negedge clk);
      r = ready[sel];
      t++;
    end
    @(posedge clk);
    check_eq($sformatf("dut%0d ready for %02h", sel, d), int'(r), 1);
    if (r === 1'b1 && push) begin
      it.sel  = 2'(sel);
      it.data = d;
      it.div  = 16'(div);
      exp_q.push_back(it);
    end
    #1;
    if (!hold) valid[sel] = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq("scoreboard drained", exp_q.size() + int'(mon_busy), 0);
  endtask

  initial begin : stim
    int bad_done, bad_line;
    reset    = 1'b1;
    baud_div = 16'd3;
    tx_data  = 8'h00;
    for (int i = 0; i < 4; i++) valid[i] = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset uart_tx", int'(line[0]), 1);
    check_eq("reset tx_ready", int'(ready[0]), 1);
    check_eq("reset tx_done", int'(done[0]), 0);
    check_eq("reset uart_state", int'(busy[0]), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("idle line", int'(line[0]), 1);

    send(0, 8'hA5, 3, 1'b0, 1'b1);
    wait_idle();

    send(1, 8'hA5, 3, 1'b0, 1'b1);
    wait_idle();
    send(2, 8'hA5, 3, 1'b0, 1'b1);
    wait_idle();

    send(3, 8'h7F, 0, 1'b0, 1'b1);
    wait_idle();

    send(0, 8'h01, 1, 1'b1, 1'b1);
    send(0, 8'h80, 1, 1'b0, 1'b1);
    wait_idle();

    send(0, 8'h5A, 3, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    baud_div = 16'd9;
    wait_idle();
    send(0, 8'hC3, 9, 1'b0, 1'b1);
    wait_idle();

    // Abort a frame during data bit 3 (0x34 has bit 3 = 0).
    send(0, 8'h34, 3, 1'b0, 1'b0);
    repeat (17) @(negedge clk);
    check_eq("pre-reset data bit3", int'(line[0]), 0);
    reset = 1'b1;
    #1;
    check_eq("abort uart_tx", int'(line[0]), 1);
    check_eq("abort uart_state", int'(busy[0]), 0);
    check_eq("abort tx_ready", int'(ready[0]), 1);
    bad_done = 0;
    bad_line = 0;
    repeat (3) begin
      @(negedge clk);
      if (done[0] !== 1'b0) bad_done++;
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done[0] !== 1'b0) bad_done++;
      if (line[0] !== 1'b1) bad_line++;
    end
    check_eq("no tx_done after abort", bad_done, 0);
    check_eq("line idle after abort", bad_line, 0);
    check_eq("tx_ready after abort", int'(ready[0]), 1);
    send(0, 8'h34, 3, 1'b0, 1'b1);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. It serialises one word per frame onto a single line, LSB first. Frame length is set at elaboration (data width, parity mode, stop bits); bit period is set at run time through a divisor input. Upstream logic hands over words with a valid/ready handshake, and back-to-back frames are sent with no idle gap.

Parameters:
DATA_BITS, 8, payload bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even; any other value is treated as 0.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
DIV_W, 16, width of the baud divisor.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
reset  in  1  asynchronous, active-high reset.
baud_div  in  DIV_W  clocks per bit minus 1; 0 gives 1 clock per bit.
tx_data  in  DATA_BITS  word to send.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  block can accept a word this cycle.
uart_tx  out  1  serial line; idles at 1.
tx_done  out  1  one-cycle pulse at the end of each frame.
uart_state  out  1  1 while a frame is in progress.

Behaviour:
- Reset values: uart_tx=1, tx_ready=1, tx_done=0, uart_state=0. All internal state returns to IDLE.
- Reset asserted mid-frame aborts the frame. uart_tx is forced to 1 asynchronously and no tx_done is issued.
- FSM states: IDLE, START, DATA, PAR, STOP.
- Transfer rule: a word transfers on a clk edge where tx_valid=1 and tx_ready=1.
  - tx_ready is a registered output, equal to 1 only in IDLE.
  - On transfer, tx_data and baud_div are latched. Later changes to either input do not affect the frame in progress.
- Latency: uart_tx drives the start bit (0) from the cycle after the transfer edge.
- Bit timing:
  - Every bit, including start, parity and stop, is held for exactly baud_div_latched+1 cycles.
  - A bit-period counter runs from 0 to baud_div_latched and wraps. The FSM advances on the wrap.
- Bit order: start(0) -> data[0]..data[DATA_BITS-1] -> parity (if PARITY≠0) -> STOP_BITS × 1.
- Parity bit:
  - Even mode: XOR of the latched data.
  - Odd mode: inverse of that XOR.
  - PAR state is skipped when PARITY=0.
- uart_tx is registered; no glitches, no combinational path from inputs.
- Frame length N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.
- Total duration: N×(baud_div+1) cycles.
- End of frame: on the wrap of the last stop bit, the FSM returns to IDLE.
  - tx_done=1 and tx_ready=1 are both asserted in the next cycle, for one cycle.
  - uart_state deasserts in that same cycle.
- Back-to-back frames:
  - If tx_valid=1 in the cycle tx_done=1, that edge transfers the next word.
  - The new start bit follows directly; no extra idle bit is inserted.
  - tx_done and tx_ready then each stay high for exactly that one cycle.
- uart_state is 1 from the cycle after a transfer edge until the cycle before tx_done.
- tx_valid while tx_ready=0 is ignored. The word is not dropped: it transfers when tx_ready rises, provided tx_valid is still held.
- Idle line: uart_tx holds 1 for as long as no transfer occurs.
- The divisor counter is DIV_W bits wide. baud_div = all-ones is legal, giving 2^DIV_W cycles per bit.

Test Plan:
1. DATA_BITS=8, PARITY=0, STOP_BITS=1, baud_div=3; send 0xA5 with transfer at edge 0.
   - uart_tx sequence: 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, spanning cycles 1..40.
   - tx_done=1 only in cycle 41; uart_state=1 in cycles 1..40.
2. Same setup with PARITY=2 (even), then PARITY=1 (odd), sending 0xA5.
   - Parity bit is 0 (even), then 1 (odd).
   - Frame is 11 bits, 44 cycles; tx_done in cycle 45.
3. DATA_BITS=7, STOP_BITS=2, baud_div=0; send 0x7F.
   - uart_tx sequence: 0,1,1,1,1,1,1,1,1,1, one cycle per bit.
   - tx_done in cycle 11.
4. tx_valid held high with two words, 0x01 then 0x80, baud_div=1.
   - The second start bit immediately follows the first frame's stop bit, with no 1-bit gap.
   - tx_ready is high for exactly 1 cycle between the frames.
5. baud_div changed from 3 to 9 mid-frame.
   - The current frame keeps 4-cycle bits.
   - The next frame uses 10-cycle bits.
6. reset pulsed during data bit 3.
   - uart_tx=1 and uart_state=0 immediately; no tx_done.
   - After release, tx_ready=1 and a fresh frame sends correctly.
